// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter: fixed-priority I-cache/D-cache arbiter issuing one single-beat AXI transaction at a time
module cache_axi_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_dok,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_dok,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [2:0] {IDLE, AR, R, AWW, B, DONE} state_t;
    state_t      state, state_n;
    logic        src;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wen_q;
    logic        aw_done, w_done, grant_data;
    assign grant_data = data_req && (DATA_FIRST || !inst_req);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (inst_req || data_req) state_n = (grant_data && data_wen != 4'b0) ? AWW : AR;
            AR:      if (arready) state_n = R;
            R:       if (rvalid) state_n = DONE;
            AWW:     if ((aw_done || awready) && (w_done || wready)) state_n = B;
            B:       if (bvalid) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            src        <= 1'b0;
            addr_q     <= '0;
            wen_q      <= '0;
            wdata_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            state   <= state_n;
            // handshake flags live only while the write is still in its address/data phase
            aw_done <= state == AWW && state_n == AWW && (aw_done || awready);
            w_done  <= state == AWW && state_n == AWW && (w_done || wready);
            if (state == IDLE && (inst_req || data_req)) begin
                src     <= grant_data;
                addr_q  <= grant_data ? data_addr : inst_addr;
                wen_q   <= grant_data ? data_wen : 4'b0;
                wdata_q <= data_wdata;
            end
            if (state == R && rvalid) begin
                if (src) data_rdata <= rdata;
                else     inst_rdata <= rdata;
            end
        end
    end
    assign araddr   = addr_q;
    assign awaddr   = addr_q;
    assign wdata    = wdata_q;
    assign wstrb    = wen_q;
    assign arvalid  = state == AR;
    assign rready   = state == R;
    assign awvalid  = state == AWW && !aw_done;
    assign wvalid   = state == AWW && !w_done;
    assign bready   = state == B;
    assign inst_dok = state == DONE && !src;
    assign data_dok = state == DONE && src;
endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Arbitrates between the instruction-cache miss port and the data-cache request port, and turns the winner into one single-beat AXI transaction. It sits directly downstream of the data cache: it consumes the cache's `req` and returns a read word plus a one-cycle `dok` completion pulse. One transaction is outstanding at a time. Burst fields are not ports; the top-level AXI wrapper ties them:
- `arlen/awlen` = 0
- `arsize/awsize` = 2
- `arburst/awburst` = INCR
- `arid/awid` = 0

## Interface
Parameters:
- DATA_FIRST, 1, 1 = data port wins a simultaneous request; 0 = instruction port wins.

Ports:
- clk  in  1  clock; all logic on the rising edge
- resetn  in  1  synchronous, active-low reset
- inst_req  in  1  instruction read request (level)
- inst_addr  in  32  instruction read address
- inst_rdata  out  32  instruction read word, valid while inst_dok=1
- inst_dok  out  1  instruction completion pulse
- data_req  in  1  data request (level)
- data_addr  in  32  data address
- data_wen  in  4  byte write enables; 0 = read
- data_wdata  in  32  write data
- data_rdata  out  32  data read word, valid while data_dok=1
- data_dok  out  1  data completion pulse
- araddr  out  32  AXI read address
- arvalid  out  1  AXI read address valid
- arready  in  1  AXI read address ready
- rdata  in  32  AXI read data
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- awaddr  out  32  AXI write address
- awvalid  out  1  AXI write address valid
- awready  in  1  AXI write address ready
- wdata  out  32  AXI write data
- wstrb  out  4  AXI write strobes
- wvalid  out  1  AXI write data valid (wlast is tied to 1 by the wrapper)
- wready  in  1  AXI write data ready
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response ready

## Operation
- The FSM has six states: IDLE, AR, R, AWW, B, DONE.
- IDLE:
  - If either req is high, grant per DATA_FIRST.
  - At grant, latch the source, the address, and (for data) wen and wdata.
  - Data with wen≠0 goes to AWW; any other grant goes to AR.
- AR: arvalid=1 and araddr=latched address. On arready, go to R.
- R:
  - rready=1.
  - On rvalid, capture rdata into the granted source's rdata register and go to DONE.
  - rresp and rid are ignored.
- AWW:
  - awvalid and wvalid start together; wstrb=latched wen.
  - Each valid drops independently after its own handshake, tracked by aw_done and w_done flags.
  - Go to B once both handshakes are done; a same-cycle double handshake goes straight to B.
- B: bready=1. On bvalid, go to DONE. bresp is ignored.
- DONE:
  - The granted source's dok=1 for exactly this cycle; then go to IDLE.
  - Requests are not sampled in DONE. This gives the requester one cycle to drop a level req that has already been served.
- inst_rdata and data_rdata are registers. Each changes only on a read capture for its own source and holds otherwise. A data write never modifies data_rdata.
- The non-granted request stays pending (level) and is served after the current transaction. There is no starvation guarantee beyond fixed priority.
- Request inputs are sampled only in IDLE. Address, wen and wdata changes after grant have no effect.

## Timing
- Reset (resetn=0 at an edge):
  - state=IDLE, all valids/readies=0, both dok=0, both rdata registers=0, aw_done and w_done cleared.
  - This applies mid-transaction too; the in-flight transaction is abandoned silently.
- Read, zero-wait slave: req high in IDLE at cycle t, arvalid at t+1, R at t+2, rvalid at t+2, dok at t+3, IDLE at t+4. The best case is 3 cycles from req to dok.
- Write, zero-wait slave: req at t, awvalid=wvalid=1 at t+1, B at t+2, bvalid at t+2, dok at t+3.
- Back-to-back: the second grant can occur at t+4 at the earliest.
- arvalid, awvalid and wvalid are registered and never drop before their handshake (AXI rule).
- rready is 1 only in R and bready is 1 only in B; rvalid or bvalid seen in any other state is not accepted.
- inst_dok and data_dok are never high in the same cycle.

## Test plan
- Data read, arready=rvalid=1 immediately, rdata=0xDEADBEEF, data_addr=0x0000_1004 -> araddr=0x0000_1004; data_dok high exactly 3 cycles after the req edge with data_rdata=0xDEADBEEF; data_rdata holds afterwards.
- Data write, data_wen=4'b0011, data_wdata=0x1234_5678, awready 2 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid after 3; wstrb=0011; a single data_dok pulse 1 cycle after bvalid; data_rdata unchanged.
- inst_req and data_req high in the same cycle, DATA_FIRST=1 -> the data transaction completes first, then the inst read is granted in the IDLE after DONE; doks never overlap.
- Requester holds data_req high through DONE, then drops it -> exactly one transaction issued; no duplicate AR/AW.
- resetn low while in R with rvalid withheld -> next cycle all valids=0, rready=0, state=IDLE; a new inst_req after reset completes normally.
- Slave asserts bvalid during AWW before the handshakes complete -> not accepted (bready=0); accepted only once the FSM is in B.
